// File: rtl/su_decode_seq.sv
// Sequential MX11SU decoder: fetch / accept / issue loop that turns instruction
// bytes into register-file/ALU micro-ops over valid/ready and counts retirements.
module su_decode_seq #(
    parameter int SEL_W    = 4,
    parameter int FLAG_W   = 8,
    parameter int CNT_W    = 16,
    parameter bit SKIP_NOP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_n,
    input  logic [FLAG_W-1:0] flags,
    input  logic [7:0]        insr,
    input  logic              insr_valid,
    output logic              insr_ready,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [SEL_W-1:0]  src_a,
    output logic [SEL_W-1:0]  src_b,
    output logic [SEL_W-1:0]  dst_f,
    output logic [3:0]        opcode,
    output logic              fetch_req,
    output logic              br_taken,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;

    state_t           state;
    logic [7:0]       insr_q;
    logic [4:0]       flags_q;
    logic [CNT_W-1:0] retired_q;

    logic [11:0]      dec_sel;
    logic [3:0]       dec_op;
    logic             dec_taken;
    logic             active;
    logic             unused_flags;

    // Flag bits above LT carry nothing this block needs.
    assign unused_flags = ^(flags >> 5);

    function automatic logic [11:0] alu_tbl(input logic [2:0] idx);
        case (idx)
            3'd0:    alu_tbl = 12'h010;
            3'd1:    alu_tbl = 12'h001;
            3'd2:    alu_tbl = 12'h002;
            3'd3:    alu_tbl = 12'h003;
            3'd4:    alu_tbl = 12'h330;
            3'd5:    alu_tbl = 12'h331;
            3'd6:    alu_tbl = 12'h332;
            default: alu_tbl = 12'h333;
        endcase
    endfunction

    function automatic logic [11:0] mov_tbl(input logic [4:0] idx);
        case (idx)
            5'd0:  mov_tbl = 12'h001;  5'd1:  mov_tbl = 12'h100;
            5'd2:  mov_tbl = 12'h002;  5'd3:  mov_tbl = 12'h200;
            5'd4:  mov_tbl = 12'h003;  5'd5:  mov_tbl = 12'h300;
            5'd6:  mov_tbl = 12'h007;  5'd7:  mov_tbl = 12'h700;
            5'd8:  mov_tbl = 12'h102;  5'd9:  mov_tbl = 12'h201;
            5'd10: mov_tbl = 12'h103;  5'd11: mov_tbl = 12'h301;
            5'd12: mov_tbl = 12'h203;  5'd13: mov_tbl = 12'h302;
            5'd14: mov_tbl = 12'h006;  5'd15: mov_tbl = 12'h600;
            5'd16: mov_tbl = 12'h800;  5'd17: mov_tbl = 12'h901;
            5'd18: mov_tbl = 12'hA02;  5'd19: mov_tbl = 12'hB03;
            5'd20: mov_tbl = 12'h008;  5'd21: mov_tbl = 12'h109;
            5'd22: mov_tbl = 12'h20A;  5'd23: mov_tbl = 12'h30B;
            5'd24: mov_tbl = 12'hC04;  5'd25: mov_tbl = 12'hD05;
            5'd26: mov_tbl = 12'hE06;  5'd27: mov_tbl = 12'hF07;
            5'd28: mov_tbl = 12'h40C;  5'd29: mov_tbl = 12'h50D;
            5'd30: mov_tbl = 12'h60E;  default: mov_tbl = 12'h70F;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [7:0] b);
        is_illegal = b[7] && (b[7:5] != 3'b100) && (b[7:4] != 4'hA);
    endfunction

    // Fields come from the state and the captured byte/flags only, so they
    // stay put whenever the state is held (back-pressure or ce_n).
    always_comb begin
        dec_sel   = 12'h000;
        dec_op    = 4'h0;
        dec_taken = 1'b0;
        case (state)
            FETCH: begin
                dec_sel = 12'h606;
                dec_op  = 4'hC;
            end
            ISSUE: begin
                if (!insr_q[7]) begin
                    dec_sel = alu_tbl(insr_q[6:4]);
                    dec_op  = insr_q[3:0];
                end else if (insr_q[7:5] == 3'b100) begin
                    dec_sel = mov_tbl(insr_q[4:0]);
                    dec_op  = insr_q[3:0];
                end else if (insr_q[7:4] == 4'hA) begin
                    case (insr_q[2:0])
                        3'd0:    dec_taken = ~flags_q[0];
                        3'd1:    dec_taken = flags_q[0];
                        3'd2:    dec_taken = ~flags_q[1];
                        3'd3:    dec_taken = flags_q[1];
                        3'd4:    dec_taken = flags_q[3];
                        3'd5:    dec_taken = flags_q[4];
                        3'd6:    dec_taken = flags_q[3] & flags_q[2];
                        default: dec_taken = flags_q[4] & flags_q[2];
                    endcase
                    if (!dec_taken) begin
                        dec_sel = 12'h606;
                    end else if (insr_q[3]) begin
                        dec_sel = 12'h663;
                        dec_op  = 4'h8;
                    end else begin
                        dec_sel = 12'h603;
                    end
                end
            end
            default: ;
        endcase
    end

    assign active     = ~rst & ~ce_n;
    assign uop_valid  = active & ((state == FETCH) | (state == ISSUE));
    assign insr_ready = active & (state == WAIT);
    assign illegal    = insr_ready & insr_valid & is_illegal(insr);
    assign fetch_req  = ~rst & (state == FETCH);
    assign br_taken   = ~rst & (state == ISSUE) & dec_taken;
    assign dst_f      = rst ? '0 : SEL_W'(dec_sel[11:8]);
    assign src_b      = rst ? '0 : SEL_W'(dec_sel[7:4]);
    assign src_a      = rst ? '0 : SEL_W'(dec_sel[3:0]);
    assign opcode     = rst ? 4'h0 : dec_op;
    assign retired    = rst ? '0 : retired_q;

    // Loop controller: a NOP retires straight from WAIT without an issue slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            insr_q    <= 8'h00;
            flags_q   <= 5'h00;
            retired_q <= '0;
        end else if (!ce_n) begin
            case (state)
                FETCH: if (uop_ready) state <= WAIT;
                WAIT: begin
                    if (insr_valid) begin
                        if (SKIP_NOP && insr == 8'h00) begin
                            retired_q <= retired_q + 1'b1;
                            state     <= FETCH;
                        end else begin
                            insr_q  <= insr;
                            flags_q <= flags[4:0];
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (uop_ready) begin
                        retired_q <= retired_q + 1'b1;
                        state     <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_su_decode_seq.sv
// Directed bench for su_decode_seq: walks the fetch/accept/issue loop through
// ALU, MOV, JMP, NOP and illegal bytes, back-pressure, ce_n freeze and reset.
module tb_su_decode_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_n;
    logic [7:0]  flags;
    logic [7:0]  insr;
    logic        insr_valid;
    logic        insr_ready;
    logic        uop_valid;
    logic        uop_ready;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_f;
    logic [3:0]  opcode;
    logic        fetch_req;
    logic        br_taken;
    logic        illegal;
    logic [15:0] retired;
    logic [15:0] uop;

    int test_count = 0;
    int fail_count = 0;

    su_decode_seq #(.SEL_W(4), .FLAG_W(8), .CNT_W(16), .SKIP_NOP(1'b1)) dut (
        .clk(clk), .rst(rst), .ce_n(ce_n), .flags(flags),
        .insr(insr), .insr_valid(insr_valid), .insr_ready(insr_ready),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .src_a(src_a), .src_b(src_b), .dst_f(dst_f), .opcode(opcode),
        .fetch_req(fetch_req), .br_taken(br_taken), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    assign uop = {dst_f, src_b, src_a, opcode};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic v, input logic [7:0] f);
        insr       = b;
        insr_valid = v;
        flags      = f;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accept one byte from WAIT and land in ISSUE (or FETCH for a NOP).
    task automatic send(input logic [7:0] b, input logic [7:0] f);
        applyStimulus(b, 1'b1, f);
        tick();
        applyStimulus(b, 1'b0, f);
    endtask

    initial begin
        rst = 1'b1; ce_n = 1'b0; uop_ready = 1'b1;
        applyStimulus(8'h00, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("rst_uop_valid", uop_valid, 0);
        checkOutput("rst_fetch_req", fetch_req, 0);
        checkOutput("rst_insr_ready", insr_ready, 0);
        checkOutput("rst_retired", retired, 0);
        checkOutput("rst_fields", uop, 16'h0000);

        rst = 1'b0; #1;
        checkOutput("fetch_valid", uop_valid, 1);
        checkOutput("fetch_req", fetch_req, 1);
        checkOutput("fetch_fields", uop, 16'h606C);
        tick();
        checkOutput("wait_ready", insr_ready, 1);
        checkOutput("wait_uop_valid", uop_valid, 0);

        // ALU 0x25: idx 2 -> dst0 b0 a2, op 5
        applyStimulus(8'h25, 1'b1, 8'h00);
        checkOutput("alu_illegal", illegal, 0);
        tick();
        applyStimulus(8'h25, 1'b0, 8'h00);
        checkOutput("alu_fields", uop, 16'h0025);
        checkOutput("alu_valid", uop_valid, 1);
        checkOutput("alu_fetch_req", fetch_req, 0);
        tick();
        checkOutput("alu_retired", retired, 1);
        checkOutput("alu_back_fetch", fetch_req, 1);
        tick();

        // MOV 0x8B: idx 11 -> 301, op B; stall 4 cycles
        send(8'h8B, 8'h00);
        checkOutput("mov8b_fields", uop, 16'h301B);
        uop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("mov8b_stall_fields", uop, 16'h301B);
            checkOutput("mov8b_stall_retired", retired, 1);
        end
        uop_ready = 1'b1;
        tick();
        checkOutput("mov8b_retired", retired, 2);
        tick();

        // MOV 0x9B: idx 27 -> F07, op B
        send(8'h9B, 8'h00);
        checkOutput("mov9b_fields", uop, 16'hF07B);
        tick();
        tick();

        // JMP 0xA9 with Z=1: relative taken; then flip Z mid-issue
        send(8'hA9, 8'h01);
        checkOutput("jmp_rel_fields", uop, 16'h6638);
        checkOutput("jmp_rel_br", br_taken, 1);
        uop_ready = 1'b0;
        applyStimulus(8'hA9, 1'b0, 8'h00);
        checkOutput("jmp_flip_fields", uop, 16'h6638);
        tick();
        checkOutput("jmp_flip_br", br_taken, 1);
        uop_ready = 1'b1;
        tick();
        checkOutput("jmp_rel_retired", retired, 4);
        tick();

        send(8'hA9, 8'h00);
        checkOutput("jmp_nt_fields", uop, 16'h6060);
        checkOutput("jmp_nt_br", br_taken, 0);
        tick();
        tick();

        // 0xA4 cond GT taken absolute; 0xA6 GT&EQ with EQ=0 not taken
        send(8'hA4, 8'h08);
        checkOutput("jmp_abs_fields", uop, 16'h6030);
        checkOutput("jmp_abs_br", br_taken, 1);
        tick();
        tick();
        send(8'hA6, 8'h08);
        checkOutput("jmp_gteq_fields", uop, 16'h6060);
        checkOutput("jmp_gteq_br", br_taken, 0);
        tick();
        checkOutput("jmp_retired", retired, 7);
        tick();

        // NOP retires directly from WAIT
        applyStimulus(8'h00, 1'b1, 8'h00);
        checkOutput("nop_illegal", illegal, 0);
        tick();
        applyStimulus(8'h00, 1'b0, 8'h00);
        checkOutput("nop_fetch", fetch_req, 1);
        checkOutput("nop_retired", retired, 8);
        tick();

        // Illegal 0xF0: pulse on accept, zero micro-op issued
        applyStimulus(8'hF0, 1'b1, 8'h00);
        checkOutput("ill_pulse", illegal, 1);
        tick();
        applyStimulus(8'hF0, 1'b0, 8'h00);
        checkOutput("ill_pulse_end", illegal, 0);
        checkOutput("ill_fields", uop, 16'h0000);
        checkOutput("ill_valid", uop_valid, 1);
        tick();
        checkOutput("ill_retired", retired, 9);
        tick();

        // ce_n freeze during ISSUE, then reset mid-issue
        send(8'h13, 8'h00);
        checkOutput("ce_fields_pre", uop, 16'h0013);
        ce_n = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("ce_valid", uop_valid, 0);
            checkOutput("ce_fields", uop, 16'h0013);
            tick();
        end
        checkOutput("ce_retired", retired, 9);
        ce_n = 1'b0; uop_ready = 1'b0; #1;
        checkOutput("ce_release_valid", uop_valid, 1);
        rst = 1'b1; #1;
        checkOutput("rst_mid_valid", uop_valid, 0);
        tick();
        rst = 1'b0; #1;
        checkOutput("rst_mid_retired", retired, 0);
        checkOutput("rst_mid_fetch", fetch_req, 1);
        checkOutput("rst_mid_fields", uop, 16'h606C);

        // insr_valid outside WAIT is ignored
        applyStimulus(8'h25, 1'b1, 8'h00);
        checkOutput("fetch_no_ready", insr_ready, 0);
        tick();
        checkOutput("fetch_held", fetch_req, 1);
        checkOutput("fetch_held_fields", uop, 16'h606C);
        applyStimulus(8'h00, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
